// File: rtl/async_fifo.sv
// Single-clock FIFO with wrap-bit pointers and registered full/empty flags.
// Optional occupancy output p_level is enabled by defining ASYNC_FIFO_LEVEL_EN.
module async_fifo #(
  parameter int unsigned BITS = 32,
  parameter int unsigned SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty
`ifdef ASYNC_FIFO_LEVEL_EN
  ,
  output logic [$clog2(SIZE):0] p_level
`endif
);

  localparam int unsigned AW = $clog2(SIZE);
  localparam int unsigned PW = AW + 1;

  logic [BITS-1:0] mem [SIZE];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   wptr_nxt;
  logic [PW-1:0]   rptr_nxt;
  logic            wr_acc;
  logic            rd_acc;
  logic            empty_nxt;
  logic            full_nxt;

  // Acceptance depends only on registered flags, so no input-to-flag path exists.
  always_comb begin
    wr_acc    = p_write_en & ~p_write_full;
    rd_acc    = p_read_en & ~p_read_empty;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    if (wr_acc) wptr_nxt = wptr + PW'(1);
    if (rd_acc) rptr_nxt = rptr + PW'(1);
    empty_nxt = (wptr_nxt == rptr_nxt);
    full_nxt  = (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
  end

  // Pointers, flags and read data
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      p_read_empty <= 1'b1;
      p_write_full <= 1'b0;
      p_read_data  <= '0;
    end else begin
      wptr         <= wptr_nxt;
      rptr         <= rptr_nxt;
      p_read_empty <= empty_nxt;
      p_write_full <= full_nxt;
      if (rd_acc) p_read_data <= mem[rptr[AW-1:0]];
    end
  end

  // Storage is not reset; pointers alone define valid contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wptr[AW-1:0]] <= p_write_data;
  end

`ifdef ASYNC_FIFO_LEVEL_EN
  logic [PW-1:0] level_nxt;

  // Modular pointer difference covers 0..SIZE thanks to the wrap bit.
  always_comb begin
    level_nxt = wptr_nxt - rptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) p_level <= '0;
    else     p_level <= level_nxt;
  end
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: a queue model predicts data, flags and level.
module tb_async_fifo;

  localparam int unsigned BITS = 32;
  localparam int unsigned SIZE = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            p_write_en = 1'b0;
  logic [BITS-1:0] p_write_data = '0;
  logic            p_write_full;
  logic            p_read_en = 1'b0;
  logic [BITS-1:0] p_read_data;
  logic            p_read_empty;
`ifdef ASYNC_FIFO_LEVEL_EN
  logic [$clog2(SIZE):0] p_level;
`endif

  async_fifo #(.BITS(BITS), .SIZE(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .p_write_en   (p_write_en),
    .p_write_data (p_write_data),
    .p_write_full (p_write_full),
    .p_read_en    (p_read_en),
    .p_read_data  (p_read_data),
    .p_read_empty (p_read_empty)
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    .p_level      (p_level)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_data = '0;
  int cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_data"},  p_read_data, exp_data);
    chk({tag, "_empty"}, 32'(p_read_empty), 32'(cnt == 0));
    chk({tag, "_full"},  32'(p_write_full), 32'(cnt == int'(SIZE)));
`ifdef ASYNC_FIFO_LEVEL_EN
    chk({tag, "_level"}, 32'(p_level), 32'(cnt));
`endif
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy.
  task automatic cycle(input logic we, input logic [31:0] wd, input logic re, input string tag);
    logic wa;
    logic ra;
    wa = we && (cnt < int'(SIZE));
    ra = re && (cnt > 0);
    if (ra) exp_data = sb.pop_front();
    if (wa) sb.push_back(wd);
    cnt = cnt + int'(wa) - int'(ra);
    p_write_en   = we;
    p_write_data = wd;
    p_read_en    = re;
    @(posedge clk);
    #1;
    p_write_en = 1'b0;
    p_read_en  = 1'b0;
    check_state(tag);
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    p_write_en = 1'b1;
    p_read_en  = 1'b1;
    p_write_data = 32'h5555_AAAA;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst        = 1'b0;
    p_write_en = 1'b0;
    p_read_en  = 1'b0;
    sb.delete();
    cnt      = 0;
    exp_data = '0;
    check_state("reset");
  endtask

  initial begin
    // Reset with both requests held high
    do_reset(3);

    // Smoke: fill 0..F, then drain in order
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), 1'b0, "smoke_wr");
    chk("smoke_full", 32'(p_write_full), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, "smoke_rd");
    chk("smoke_last", p_read_data, 32'h0000_000F);
    chk("smoke_empty", 32'(p_read_empty), 32'd1);

    // Overflow: write while full is dropped
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, "ovf_fill");
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, "ovf_wr");
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, '0, 1'b1, "ovf_rd");
      if (p_read_data == 32'hDEAD_BEEF) chk("ovf_leak", p_read_data, 32'h100 + 32'(i));
    end
    // Underflow: read while empty leaves data and pointers untouched
    cycle(1'b0, '0, 1'b1, "udf_rd");
    chk("udf_hold", p_read_data, 32'h0000_010F);
    cycle(1'b1, 32'h0000_0777, 1'b0, "udf_wr");
    cycle(1'b0, '0, 1'b1, "udf_rdback");
    chk("udf_ptr", p_read_data, 32'h0000_0777);

    // Boundary: read+write while empty accepts only the write
    cycle(1'b1, 32'h0000_0BB0, 1'b1, "bnd_empty");
    chk("bnd_empty_flag", 32'(p_read_empty), 32'd0);
    for (int i = 1; i < 16; i++) cycle(1'b1, 32'h0BB0 + 32'(i), 1'b0, "bnd_fill");
    // Read+write while full accepts only the read
    cycle(1'b1, 32'h0000_0CCC, 1'b1, "bnd_full");
    chk("bnd_full_flag", 32'(p_write_full), 32'd0);
    chk("bnd_full_data", p_read_data, 32'h0000_0BB0);
    for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, "bnd_drain");

    // Interleaved streaming across many pointer wraps
    cycle(1'b1, 32'h1000, 1'b0, "il_pre");
    for (int i = 1; i <= 100; i++) cycle(1'b1, 32'h1000 + 32'(i), 1'b1, "il_a");
    for (int i = 0; i < 14; i++) cycle(1'b1, 32'h2000 + 32'(i), 1'b0, "il_grow");
    for (int i = 0; i < 20; i++) cycle(1'b1, 32'h3000 + 32'(i), 1'b1, "il_b");
    while (cnt > 0) cycle(1'b0, '0, 1'b1, "il_drain");

    // Mid-operation reset discards stored entries
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h4000 + 32'(i), 1'b0, "mr_wr");
    do_reset(1);
    chk("mr_empty", 32'(p_read_empty), 32'd1);
    cycle(1'b0, '0, 1'b1, "mr_rd_ign");
    cycle(1'b1, 32'hA5A5_A5A5, 1'b0, "mr_wr_new");
    cycle(1'b0, '0, 1'b1, "mr_rd_new");
    chk("mr_first", p_read_data, 32'hA5A5_A5A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
